serial_add_ctrl: RTL and testbench

- Sequencer that time-shares one 1-bit full adder (`fa`) to add two WIDTH-bit operands bit-serially, LSB first.
- Operands are captured on a valid/ready input handshake and shifted through the `fa` one bit per clock, with the carry registered between bits.
- The sum is presented on a valid/ready output handshake.
- Sits in the arithmetic datapath wherever adder area matters more than throughput.

---
 rtl/serial_add_defs.sv | 15 +
 rtl/fa.sv | 20 ++
 rtl/serial_add_ctrl.sv | 138 +++++++++++++
 tb/tb_serial_add_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_defs.sv
// serial_add_defs
// Shared definitions for the bit-serial adder controller.
//   state_t       : controller FSM encoding (IDLE, RUN, DONE)
//   DEFAULT_WIDTH : default operand width in bits
package serial_add_defs;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fa.sv
// fa
// Single-bit full adder. This is the one bit-slice that the serial
// controller reuses for every bit position.
// Ports:
//   x, y : addend bits
//   ci   : carry in
//   s    : sum bit
//   co   : carry out
module fa (
  output logic co,
  output logic s,
  input  logic ci,
  input  logic x,
  input  logic y
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
// Bit-serial adder. It routes two WIDTH-bit operands through one shared
// full adder, LSB first, and registers the carry between bit positions.
// Optional build macro: SERIAL_ADD_OVF_EN adds the signed-overflow output ovf.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (x, y, ci captured on accept)
//   x, y, ci            : addends and carry-in for bit 0
//   out_valid/out_ready : result handshake
//   s, co               : sum and carry-out of the MSB
//   ovf                 : signed overflow (only when SERIAL_ADD_OVF_EN is defined)
module serial_add_ctrl
  import serial_add_defs::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] x_sr;
  logic [WIDTH-1:0] y_sr;
  logic [WIDTH-1:0] s_reg;
  logic             carry;
  logic             co_reg;
  logic             fa_s;
  logic             fa_co;
  logic             accept;
  logic             last_bit;

  fa u_fa (
    .co (fa_co),
    .s  (fa_s),
    .ci (carry),
    .x  (x_sr[0]),
    .y  (y_sr[0])
  );

  assign accept   = in_ready & in_valid;
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));
  assign s        = s_reg;
  assign co       = co_reg;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and handshake outputs. in_ready is purely a decode of
  // IDLE, so operands offered in RUN or DONE are never taken.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = RUN;
      end
      RUN: begin
        if (last_bit) next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Serial datapath. Each RUN cycle consumes the operand LSBs and shifts the
  // new sum bit in at the MSB. After WIDTH cycles, the first sum bit has
  // reached bit 0. The MSB assignment overrides the shift for that one bit.
  // The result registers are left alone outside RUN, so s and co stay stable
  // through DONE and after the result handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      x_sr   <= '0;
      y_sr   <= '0;
      s_reg  <= '0;
      carry  <= 1'b0;
      co_reg <= 1'b0;
    end else if (accept) begin
      x_sr  <= x;
      y_sr  <= y;
      carry <= ci;
      cnt   <= '0;
    end else if (state == RUN) begin
      x_sr            <= x_sr >> 1;
      y_sr            <= y_sr >> 1;
      s_reg           <= s_reg >> 1;
      s_reg[WIDTH-1]  <= fa_s;
      carry           <= fa_co;
      cnt             <= cnt + CNT_W'(1);
      if (last_bit) co_reg <= fa_co;
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  logic ovf_reg;

  // Signed overflow happens when the carry into the MSB differs from the
  // carry out of it. Both carries exist only during the last RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_reg <= 1'b0;
    end else if (state == RUN && last_bit) begin
      ovf_reg <= carry ^ fa_co;
    end
  end

  assign ovf = ovf_reg;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl
// Scoreboard bench for serial_add_ctrl (WIDTH = 8). The stimulus pushes
// expected results, computed with plain integer arithmetic, into a queue.
// A negedge monitor compares the results whenever out_valid is high.
module tb_serial_add_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] x = '0;
  logic [WIDTH-1:0] y = '0;
  logic             ci = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] s;
  logic             co;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf;
`endif

  typedef struct {
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ovf;
    int unsigned      accept_edge;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          fails = 0;
  int unsigned edge_cnt = 0;
  bit          rand_ready = 1'b1;
  bit          prev_ov = 1'b0;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .ci        (ci),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .co        (co)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Reference model: {co, s} = x + y + ci. Signed overflow means that the
  // operands have equal signs and the sign of the sum differs from them.
  function automatic exp_t model(input logic [WIDTH-1:0] ax, input logic [WIDTH-1:0] ay,
                                 input logic aci);
    exp_t        r;
    int unsigned total;
    total    = int'(ax) + int'(ay) + int'(aci);
    r.s      = WIDTH'(total);
    r.co     = (total >= (1 << WIDTH));
    r.ovf    = (ax[WIDTH-1] == ay[WIDTH-1]) && (r.s[WIDTH-1] != ax[WIDTH-1]);
    r.accept_edge = 0;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: compares every cycle in which a result is presented. It checks
  // the latency on the first cycle and pops the expected result on the handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid) begin
        checkOutput("in_ready_in_done", in_ready, 0);
        if (exp_q.size() == 0) begin
          if (!prev_ov) checkOutput("unexpected_result", 1, 0);
        end else begin
          if (!prev_ov) checkOutput("latency", edge_cnt - exp_q[0].accept_edge, WIDTH);
          checkOutput("s", s, exp_q[0].s);
          checkOutput("co", co, exp_q[0].co);
`ifdef SERIAL_ADD_OVF_EN
          checkOutput("ovf", ovf, exp_q[0].ovf);
`endif
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      prev_ov = out_valid;
    end
  end

  // Random consumer backpressure. It changes out_ready just after posedge, so
  // the monitor and the DUT see the same value.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic applyStimulus(input logic [WIDTH-1:0] ax, input logic [WIDTH-1:0] ay,
                               input logic aci, input bit scramble);
    int   n;
    exp_t e;
    n = 0;
    @(posedge clk);
    #2;
    while (!in_ready && n < 200) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (!in_ready) begin
      checkOutput("accept_timeout", 0, 1);
      return;
    end
    x        = ax;
    y        = ay;
    ci       = aci;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    e             = model(ax, ay, aci);
    e.accept_edge = edge_cnt;
    exp_q.push_back(e);
    #1;
    in_valid = 1'b0;
    if (scramble) begin
      x  = WIDTH'($urandom);
      y  = WIDTH'($urandom);
      ci = 1'($urandom);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checkOutput("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n;

    // Outputs while reset is held.
    #12;
    checkOutput("rst_s", s, 0);
    checkOutput("rst_co", co, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_in_ready", in_ready, 1);
`ifdef SERIAL_ADD_OVF_EN
    checkOutput("rst_ovf", ovf, 0);
`endif
    #5 rst_n = 1'b1;

    // Directed vectors. The operands are scrambled after the accept edge
    // to confirm that only the captured values are used.
    applyStimulus(8'h0F, 8'h01, 1'b0, 1'b1);
    applyStimulus(8'hFF, 8'h01, 1'b0, 1'b1);
    applyStimulus(8'h7F, 8'h01, 1'b0, 1'b1);
    applyStimulus(8'h00, 8'h00, 1'b1, 1'b1);
    applyStimulus(8'h80, 8'h80, 1'b1, 1'b0);
    drain();

    // Backpressure: hold DONE for 5 cycles and offer new operands meanwhile.
    rand_ready = 1'b0;
    @(posedge clk);
    #2 out_ready = 1'b0;
    applyStimulus(8'h3C, 8'h5A, 1'b1, 1'b0);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    checkOutput("done_reached", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #2;
      in_valid = (i == 2);
      x        = 8'h11;
      y        = 8'h22;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("in_ready_after_release", in_ready, 1);
    checkOutput("out_valid_after_release", out_valid, 0);
    checkOutput("s_kept", s, 8'h97);
    #1 out_ready = 1'b0;
    rand_ready = 1'b1;
    repeat (12) @(negedge clk);
    checkOutput("queue_empty_after_bp", exp_q.size(), 0);

    // Assert reset partway through an operation.
    applyStimulus(8'hAA, 8'h55, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_s", s, 0);
    checkOutput("midrst_co", co, 0);
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_in_ready", in_ready, 1);
`ifdef SERIAL_ADD_OVF_EN
    checkOutput("midrst_ovf", ovf, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(8'hAA, 8'h55, 1'b0, 1'b0);
    drain();

    // Random operations with random backpressure.
    for (int i = 0; i < 40; i++) begin
      applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom));
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
